// File: rtl/draw_background_scroll_pkg.sv
// draw_pkg: shared constants for the scrolling background renderer.
//   - 12-bit RGB colour constants (black, yellow, red, green, blue)
//   - default active-area dimensions
//   - packed timing-bus type carried through the delay pipeline
package draw_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned V_ACTIVE_DEF = 1024;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_YELLOW = 12'hFF0;
  localparam logic [11:0] COL_RED    = 12'hF00;
  localparam logic [11:0] COL_GREEN  = 12'h0F0;
  localparam logic [11:0] COL_BLUE   = 12'h00F;

  typedef struct packed {
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
  } timing_t;

endpackage

// File: rtl/draw_background_scroll_delay_line.sv
// delay_line: fixed-depth register pipeline with asynchronous active-low reset.
//   i_clk   : clock
//   i_rst_n : async active-low reset, clears every stage
//   i_d     : WIDTH-bit input
//   o_q     : i_d delayed by exactly DEPTH cycles (DEPTH >= 1)
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_background_scroll.sv
// draw_background_scroll: vertically scrolling tiled background.
//   pclk_in / rst_in            : pixel clock, async active-low reset
//   vcount_in..hblnk_in         : input timing bus
//   scroll_en, scroll_step      : per-frame advance enable and step (lines)
//   scroll_load, scroll_value   : one-cycle load of the scroll offset
//   pixel_addr                  : combinational tile-ROM address {row, col}
//   rgb_pixel                   : ROM data, valid ROM_LAT cycles after address
//   vcount_out..hblnk_out       : timing bus delayed ROM_LAT+1 cycles
//   rgb_out                     : colour aligned with the delayed timing bus
//   scroll_offset, frame_tick   : current offset, one-cycle pulse per frame
// Optional feature macro: DRAW_BG_BORDER_EN (coloured border on active edges).
module draw_background_scroll
  import draw_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned TILE_W_LOG2 = 6,
  parameter int unsigned TILE_H_LOG2 = 6,
  parameter int unsigned ROM_LAT     = 1
) (
  input  logic                             pclk_in,
  input  logic                             rst_in,
  input  logic [10:0]                      vcount_in,
  input  logic [10:0]                      hcount_in,
  input  logic                             vsync_in,
  input  logic                             vblnk_in,
  input  logic                             hsync_in,
  input  logic                             hblnk_in,
  input  logic                             scroll_en,
  input  logic [3:0]                       scroll_step,
  input  logic                             scroll_load,
  input  logic [TILE_H_LOG2-1:0]           scroll_value,
  output logic [TILE_H_LOG2+TILE_W_LOG2-1:0] pixel_addr,
  input  logic [11:0]                      rgb_pixel,
  output logic [10:0]                      vcount_out,
  output logic [10:0]                      hcount_out,
  output logic                             vsync_out,
  output logic                             vblnk_out,
  output logic                             hsync_out,
  output logic                             hblnk_out,
  output logic [11:0]                      rgb_out,
  output logic [TILE_H_LOG2-1:0]           scroll_offset,
  output logic                             frame_tick
);

  // Counters are 11 bits wide; this empty block only elaborates for
  // configurations the timing bus cannot represent.
  if (H_ACTIVE > 2048 || V_ACTIVE > 2048 || ROM_LAT < 1 || ROM_LAT > 4) begin : g_param_out_of_range
  end

  // ---------------- scroll offset and frame tick ----------------
  logic                   r_vblnk_d;
  logic                   r_tick;
  logic [TILE_H_LOG2-1:0] r_off;

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vblnk_d <= 1'b0;
      r_tick    <= 1'b0;
      r_off     <= '0;
    end else begin
      r_vblnk_d <= vblnk_in;
      r_tick    <= vblnk_in & ~r_vblnk_d;
      // A load always wins over the frame advance.
      if (scroll_load)
        r_off <= scroll_value;
      else if (r_tick && scroll_en)
        r_off <= r_off + TILE_H_LOG2'(scroll_step);
    end
  end

  assign scroll_offset = r_off;
  assign frame_tick    = r_tick;

  // ---------------- ROM address ----------------
  logic [TILE_H_LOG2-1:0] w_row;
  assign w_row      = vcount_in[TILE_H_LOG2-1:0] + r_off;
  assign pixel_addr = {w_row, hcount_in[TILE_W_LOG2-1:0]};

  // ---------------- timing pipeline ----------------
  timing_t w_tin;
  timing_t w_tout;

  assign w_tin = '{vcount: vcount_in, hcount: hcount_in, vsync: vsync_in,
                   vblnk: vblnk_in, hsync: hsync_in, hblnk: hblnk_in};

  delay_line #(.WIDTH($bits(timing_t)), .DEPTH(ROM_LAT + 1)) u_timing (
    .i_clk   (pclk_in),
    .i_rst_n (rst_in),
    .i_d     (w_tin),
    .o_q     (w_tout)
  );

  assign vcount_out = w_tout.vcount;
  assign hcount_out = w_tout.hcount;
  assign vsync_out  = w_tout.vsync;
  assign vblnk_out  = w_tout.vblnk;
  assign hsync_out  = w_tout.hsync;
  assign hblnk_out  = w_tout.hblnk;

  // ---------------- colour select ----------------
  // Decision is made on the input-side pixel and carried alongside the ROM
  // read; the final mux picks ROM data or the fixed colour when data arrives.
  logic        w_use_rom;
  logic [11:0] w_fixed;

`ifdef DRAW_BG_BORDER_EN
  localparam logic [10:0] L_V_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] L_H_LAST = 11'(H_ACTIVE - 1);
`endif

  always_comb begin
    w_use_rom = 1'b0;
    w_fixed   = COL_BLACK;
    if (!(vblnk_in || hblnk_in)) begin
`ifdef DRAW_BG_BORDER_EN
      if (vcount_in == 11'd0)           w_fixed = COL_YELLOW;
      else if (vcount_in == L_V_LAST)   w_fixed = COL_RED;
      else if (hcount_in == 11'd0)      w_fixed = COL_GREEN;
      else if (hcount_in == L_H_LAST)   w_fixed = COL_BLUE;
      else                              w_use_rom = 1'b1;
`else
      w_use_rom = 1'b1;
`endif
    end
  end

  logic [12:0] w_sel_d;

  delay_line #(.WIDTH(13), .DEPTH(ROM_LAT)) u_colour (
    .i_clk   (pclk_in),
    .i_rst_n (rst_in),
    .i_d     ({w_use_rom, w_fixed}),
    .o_q     (w_sel_d)
  );

  logic [11:0] r_rgb;

  always_ff @(posedge pclk_in or negedge rst_in) begin
    if (!rst_in) r_rgb <= '0;
    else         r_rgb <= w_sel_d[12] ? rgb_pixel : w_sel_d[11:0];
  end

  assign rgb_out = r_rgb;

endmodule

// File: tb/tb_draw_background_scroll.sv
module tb_draw_background_scroll;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic        scroll_en;
  logic [3:0]  scroll_step;
  logic        scroll_load;
  logic [5:0]  scroll_value;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic [10:0] vcount_out, hcount_out;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;
  logic [5:0]  scroll_offset;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM model with 2-cycle latency: colour equals address.
  logic [11:0] r_rom1, r_rom2;
  always_ff @(posedge clk) begin
    r_rom1 <= pixel_addr;
    r_rom2 <= r_rom1;
  end
  assign rgb_pixel = r_rom2;

  draw_background_scroll #(.ROM_LAT(2)) dut (
    .pclk_in       (clk),
    .rst_in        (rst_n),
    .vcount_in     (vcount_in),
    .hcount_in     (hcount_in),
    .vsync_in      (vsync_in),
    .vblnk_in      (vblnk_in),
    .hsync_in      (hsync_in),
    .hblnk_in      (hblnk_in),
    .scroll_en     (scroll_en),
    .scroll_step   (scroll_step),
    .scroll_load   (scroll_load),
    .scroll_value  (scroll_value),
    .pixel_addr    (pixel_addr),
    .rgb_pixel     (rgb_pixel),
    .vcount_out    (vcount_out),
    .hcount_out    (hcount_out),
    .vsync_out     (vsync_out),
    .vblnk_out     (vblnk_out),
    .hsync_out     (hsync_out),
    .hblnk_out     (hblnk_out),
    .rgb_out       (rgb_out),
    .scroll_offset (scroll_offset),
    .frame_tick    (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold one pixel for ROM_LAT+1 edges, then check its colour on rgb_out.
  task automatic pix(input string tag, input int h, input int v, input logic hb,
                     input logic [11:0] exp);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    repeat (3) @(negedge clk);
    check(tag, rgb_out, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    vcount_in = 11'd3; hcount_in = 11'd5;
    vsync_in = 1'b0; vblnk_in = 1'b0; hsync_in = 1'b0; hblnk_in = 1'b1;
    scroll_en = 1'b0; scroll_step = 4'd0; scroll_load = 1'b0; scroll_value = 6'd0;
    repeat (2) @(negedge clk);

    check("rst_rgb", rgb_out, 0);
    check("rst_hcnt", hcount_out, 0);
    check("rst_vcnt", vcount_out, 0);
    check("rst_off", scroll_offset, 0);
    check("rst_tick", frame_tick, 0);
    check("rst_addr", pixel_addr, 12'h0C5);

    // Latency: pixel (5,3) appears after exactly 3 edges.
    rst_n = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b1;
    @(negedge clk);
    check("lat1_hcnt", hcount_out, 0);
    @(negedge clk);
    check("lat2_hcnt", hcount_out, 0);
    check("lat2_rgb", rgb_out, 0);
    check("lat2_vsync", vsync_out, 0);
    @(negedge clk);
    check("lat3_hcnt", hcount_out, 5);
    check("lat3_vcnt", vcount_out, 3);
    check("lat3_rgb", rgb_out, 12'h0C5);
    check("lat3_vsync", vsync_out, 1);

    // Load 60, then advance by 9 with wrap to 5.
    vsync_in = 1'b0; scroll_load = 1'b1; scroll_value = 6'd60;
    @(negedge clk);
    scroll_load = 1'b0;
    check("load60", scroll_offset, 60);
    check("addr60", pixel_addr, 12'hFC5);
    scroll_en = 1'b1; scroll_step = 4'd9; vblnk_in = 1'b1;
    @(negedge clk);
    check("tick_on", frame_tick, 1);
    check("off_pre", scroll_offset, 60);
    @(negedge clk);
    check("tick_off", frame_tick, 0);
    check("wrap5", scroll_offset, 5);
    check("addr5", pixel_addr, 12'h205);
    @(negedge clk);
    check("vblnk_rgb", rgb_out, 0);
    check("vblnk_out", vblnk_out, 1);
    check("hold5", scroll_offset, 5);
    check("no_retick", frame_tick, 0);

    // Step 0: tick still pulses, offset unchanged.
    scroll_step = 4'd0; vblnk_in = 1'b0;
    repeat (2) @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    check("step0_tick", frame_tick, 1);
    @(negedge clk);
    check("step0_off", scroll_offset, 5);

    // Collision: load 17 while frame_tick is high with step 4.
    scroll_step = 4'd4; vblnk_in = 1'b0;
    @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    check("coll_tick", frame_tick, 1);
    scroll_load = 1'b1; scroll_value = 6'd17;
    @(negedge clk);
    scroll_load = 1'b0;
    check("coll_off", scroll_offset, 17);

    // Disabled: tick pulses, no advance.
    scroll_en = 1'b0; vblnk_in = 1'b0;
    @(negedge clk);
    vblnk_in = 1'b1;
    @(negedge clk);
    check("dis_tick", frame_tick, 1);
    @(negedge clk);
    check("dis_off", scroll_offset, 17);
    vblnk_in = 1'b0;

    // Colour selection with offset 17.
`ifdef DRAW_BG_BORDER_EN
    pix("pix_0_0", 0, 0, 1'b0, 12'hFF0);
    pix("pix_1279_500", 1279, 500, 1'b0, 12'h00F);
    pix("pix_0_1023", 0, 1023, 1'b0, 12'hF00);
    pix("pix_0_500", 0, 500, 1'b0, 12'h0F0);
`else
    pix("pix_0_0", 0, 0, 1'b0, 12'h440);
    pix("pix_1279_500", 1279, 500, 1'b0, 12'h17F);
    pix("pix_0_1023", 0, 1023, 1'b0, 12'h400);
    pix("pix_0_500", 0, 500, 1'b0, 12'h140);
`endif
    pix("pix_hblnk", 0, 0, 1'b1, 12'h000);
    pix("pix_100_200", 100, 200, 1'b0, 12'h664);
    check("pix_hcnt", hcount_out, 100);

    // Asynchronous reset mid-line.
    #2 rst_n = 1'b0;
    #1;
    check("arst_hcnt", hcount_out, 0);
    check("arst_vcnt", vcount_out, 0);
    check("arst_rgb", rgb_out, 0);
    check("arst_off", scroll_offset, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel1_rgb", rgb_out, 0);
    check("rel1_tick", frame_tick, 0);
    @(negedge clk);
    check("rel2_rgb", rgb_out, 0);
    check("rel2_hcnt", hcount_out, 0);
    @(negedge clk);
    check("rel3_rgb", rgb_out, 12'h224);
    check("rel3_hcnt", hcount_out, 100);
    check("rel3_tick", frame_tick, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
